// File: rtl/idli_pkg.sv
// Shared pipeline types and SQI SRAM controller constants.
package idli_pkg;

    typedef logic [1:0] ctr_t;

    // Element 0 is the most significant nibble, bits [15:12].
    typedef logic [0:3][3:0] data_t;

    localparam ctr_t CTR_LAST = 2'd3;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SQI_CMD_EQIO  = 8'h38;

    typedef enum logic [2:0] {
        SQI_IDLE,
        SQI_WAIT,
        SQI_CMD,
        SQI_ADDR,
        SQI_DUMMY,
        SQI_RDATA,
        SQI_WDATA,
        SQI_INIT
    } sqi_state_t;

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM controller and owner of the free-running 4-phase sync counter.
// Optional `IDLI_SQI_EQIO_INIT_EN: send EQIO in SPI mode after reset before accepting requests.
//   state | meaning
//   IDLE  | CS released, waiting for req at ctr==3
//   WAIT  | write only, 2 idle cycles so CMD lands on ctr==2
//   CMD   | command byte, 2 nibbles
//   ADDR  | address nibbles, MSB first
//   DUMMY | read turnaround, SIO released
//   RDATA | read words, one nibble per cycle
//   WDATA | write words, one nibble per cycle
//   INIT  | EQIO command on sio[0], bit-serial
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DUMMY_NIB = 2
) (
    input  logic              i_sq_gck,
    input  logic              i_sq_rst,
    output logic [1:0]        o_sq_ctr,
    input  logic              i_sq_req,
    input  logic              i_sq_wr,
    input  logic [ADDR_W-1:0] i_sq_addr,
    input  logic              i_sq_stop,
    input  logic [15:0]       i_sq_wr_data,
    output logic              o_sq_busy,
    output logic [15:0]       o_sq_rd_data,
    output logic              o_sq_rd_vld,
    output logic              o_sq_cs_n,
    output logic              o_sq_sio_oe,
    output logic [3:0]        o_sq_sio,
    input  logic [3:0]        i_sq_sio
);

    localparam int         ADDR_NIB   = ADDR_W / 4;
    localparam logic [2:0] ADDR_LAST  = 3'(ADDR_NIB - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIB - 1);
    localparam logic [2:0] INIT_LAST  = 3'd7;

`ifdef IDLI_SQI_EQIO_INIT_EN
    localparam sqi_state_t RST_STATE = SQI_INIT;
`else
    localparam sqi_state_t RST_STATE = SQI_IDLE;
`endif

    ctr_t              ctr_q;
    sqi_state_t        state_q;
    sqi_state_t        state_d;
    logic [2:0]        step_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    data_t             wdata_q;
    logic [0:2][3:0]   rd_q;

    logic              accept;
    logic              stop_now;
    logic [7:0]        cmd_byte;
    logic [7:0]        eqio_sh;
    logic [ADDR_W-1:0] addr_sh;

    assign accept   = (state_q == SQI_IDLE) && (ctr_q == CTR_LAST) && i_sq_req;
    assign stop_now = (ctr_q == CTR_LAST) && i_sq_stop;
    assign cmd_byte = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;
    assign eqio_sh  = SQI_CMD_EQIO << step_q;
    assign addr_sh  = addr_q << {step_q, 2'b00};

    always_ff @(posedge i_sq_gck) begin
        if (i_sq_rst) begin
            ctr_q   <= '0;
            state_q <= RST_STATE;
            step_q  <= '0;
        end else begin
            ctr_q   <= ctr_q + 2'd1;
            state_q <= state_d;
            step_q  <= (state_d != state_q) ? 3'd0 : step_q + 3'd1;
        end
    end

    // The first write word rides with req; later words are taken at each data ctr==3.
    always_ff @(posedge i_sq_gck) begin
        if (i_sq_rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            if (accept) begin
                wr_q    <= i_sq_wr;
                addr_q  <= i_sq_addr;
                wdata_q <= i_sq_wr_data;
            end else if ((state_q == SQI_WDATA) && (ctr_q == CTR_LAST)) begin
                wdata_q <= i_sq_wr_data;
            end
            if (state_q == SQI_RDATA) begin
                case (ctr_q)
                    2'd0:    rd_q[0] <= i_sq_sio;
                    2'd1:    rd_q[1] <= i_sq_sio;
                    2'd2:    rd_q[2] <= i_sq_sio;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        o_sq_cs_n   = 1'b1;
        o_sq_sio_oe = 1'b0;
        o_sq_sio    = 4'h0;
        case (state_q)
            SQI_IDLE: begin
                if (accept) state_d = i_sq_wr ? SQI_WAIT : SQI_CMD;
            end
            SQI_WAIT: begin
                if (step_q == 3'd1) state_d = SQI_CMD;
            end
            SQI_CMD: begin
                o_sq_cs_n   = 1'b0;
                o_sq_sio_oe = 1'b1;
                o_sq_sio    = step_q[0] ? cmd_byte[3:0] : cmd_byte[7:4];
                if (step_q == 3'd1) state_d = SQI_ADDR;
            end
            SQI_ADDR: begin
                o_sq_cs_n   = 1'b0;
                o_sq_sio_oe = 1'b1;
                o_sq_sio    = addr_sh[ADDR_W-1 -: 4];
                if (step_q == ADDR_LAST) state_d = wr_q ? SQI_WDATA : SQI_DUMMY;
            end
            SQI_DUMMY: begin
                o_sq_cs_n = 1'b0;
                if (step_q == DUMMY_LAST) state_d = SQI_RDATA;
            end
            SQI_RDATA: begin
                o_sq_cs_n = 1'b0;
                if (stop_now) state_d = SQI_IDLE;
            end
            SQI_WDATA: begin
                o_sq_cs_n   = 1'b0;
                o_sq_sio_oe = 1'b1;
                o_sq_sio    = wdata_q[ctr_q];
                if (stop_now) state_d = SQI_IDLE;
            end
            SQI_INIT: begin
                o_sq_cs_n   = 1'b0;
                o_sq_sio_oe = 1'b1;
                o_sq_sio    = {3'b000, eqio_sh[7]};
                if (step_q == INIT_LAST) state_d = SQI_IDLE;
            end
            default: state_d = SQI_IDLE;
        endcase
    end

    // Last read nibble bypasses the flops so the word is complete on ctr==3.
    assign o_sq_ctr     = ctr_q;
    assign o_sq_busy    = (state_q != SQI_IDLE);
    assign o_sq_rd_vld  = (state_q == SQI_RDATA) && (ctr_q == CTR_LAST);
    assign o_sq_rd_data = {rd_q, i_sq_sio};

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: per-cycle pin/status expectations built from transaction descriptions.
module tb_idli_sqi_ctrl_m;

`ifdef IDLI_SQI_EQIO_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  sio_in = '0;

    logic [1:0]  ctr;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_vld;
    logic        cs_n;
    logic        oe;
    logic [3:0]  sio;

    idli_sqi_ctrl_m dut (
        .i_sq_gck     (clk),
        .i_sq_rst     (rst),
        .o_sq_ctr     (ctr),
        .i_sq_req     (req),
        .i_sq_wr      (wr),
        .i_sq_addr    (addr),
        .i_sq_stop    (stop),
        .i_sq_wr_data (wr_data),
        .o_sq_busy    (busy),
        .o_sq_rd_data (rd_data),
        .o_sq_rd_vld  (rd_vld),
        .o_sq_cs_n    (cs_n),
        .o_sq_sio_oe  (oe),
        .o_sq_sio     (sio),
        .i_sq_sio     (sio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs_n;
        logic        oe;
        logic [3:0]  sio;
        logic [3:0]  sin;
        logic        vld;
        logic [15:0] rdw;
        logic [15:0] wrd;
        logic        stop;
        logic        stop_fixed;
    } exp_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          ctr_m = 0;
    logic [15:0] words [0:3];

    // Advance one clock; the model counter restarts at 0 on any cycle reset was sampled.
    task automatic cyc();
        @(posedge clk);
        ctr_m = rst ? 0 : (ctr_m + 1) % 4;
        #2;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 1'b0;
        stop = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic skip_init();
        for (int i = 0; i < (INIT_EN ? 8 : 0); i++) cyc();
    endtask

    function automatic exp_t base_e(input bit w);
        exp_t e;
        e = '{default: '0};
        e.cs_n = 1'b0;
        e.sin  = 4'($urandom);
        e.wrd  = w ? words[0] : 16'($urandom);
        return e;
    endfunction

    task automatic run_txn(input bit w, input logic [15:0] a, input int nw, input bit noise, input string tag);
        exp_t       q[$];
        exp_t       e;
        logic [7:0] cmd;
        logic [3:0] nib;
        logic [5:0] act_p, exp_p;
        logic [3:0] act_s, exp_s;
        cmd = w ? 8'h02 : 8'h03;
        if (w) begin
            for (int i = 0; i < 2; i++) begin
                e = base_e(w);
                e.cs_n = 1'b1;
                q.push_back(e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            e = base_e(w);
            e.oe  = 1'b1;
            e.sio = (i == 0) ? cmd[7:4] : cmd[3:0];
            q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e = base_e(w);
            e.oe  = 1'b1;
            e.sio = 4'(a >> (12 - 4 * i));
            q.push_back(e);
        end
        if (!w) begin
            for (int i = 0; i < 2; i++) q.push_back(base_e(w));
        end
        for (int wd = 0; wd < nw; wd++) begin
            for (int k = 0; k < 4; k++) begin
                e   = base_e(w);
                nib = 4'(words[wd] >> (12 - 4 * k));
                if (w) begin
                    e.oe  = 1'b1;
                    e.sio = nib;
                    e.wrd = (k == 3 && wd + 1 < nw) ? words[wd + 1] : 16'($urandom);
                end else begin
                    e.sin = nib;
                    e.vld = (k == 3);
                    e.rdw = words[wd];
                end
                if (k == 3) begin
                    e.stop_fixed = 1'b1;
                    e.stop       = (wd == nw - 1);
                end
                q.push_back(e);
            end
        end

        while (ctr_m != 3) begin
            req    = 1'b0;
            stop   = noise ? 1'($urandom) : 1'b0;
            sio_in = 4'($urandom);
            cyc();
        end
        req     = 1'b1;
        wr      = w;
        addr    = a;
        wr_data = words[0];
        stop    = noise ? 1'($urandom) : 1'b0;
        sio_in  = 4'($urandom);
        #1;
        if ({busy, cs_n} !== 2'b01) begin
            n_err++;
            $display("FAIL %s idle-at-req: got busy,cs_n=%b want 01", tag, {busy, cs_n});
        end
        n_chk++;
        cyc();

        foreach (q[i]) begin
            e       = q[i];
            req     = noise ? 1'($urandom) : 1'b0;
            wr      = 1'($urandom);
            addr    = 16'($urandom);
            wr_data = e.wrd;
            sio_in  = e.sin;
            stop    = e.stop_fixed ? e.stop : (noise ? 1'($urandom) : 1'b0);
            #1;
            act_p = {cs_n, oe, e.oe ? sio : 4'h0};
            exp_p = {e.cs_n, e.oe, e.sio};
            if (act_p !== exp_p) begin
                n_err++;
                $display("FAIL %s pins cyc%0d: got cs_n,oe,sio=%b want %b", tag, i, act_p, exp_p);
            end
            n_chk++;
            act_s = {ctr, busy, rd_vld};
            exp_s = {2'(ctr_m), 1'b1, e.vld};
            if (act_s !== exp_s) begin
                n_err++;
                $display("FAIL %s status cyc%0d: got ctr,busy,vld=%b want %b", tag, i, act_s, exp_s);
            end
            n_chk++;
            if (e.vld) begin
                if (rd_data !== e.rdw) begin
                    n_err++;
                    $display("FAIL %s rd_data cyc%0d: got %h want %h", tag, i, rd_data, e.rdw);
                end
                n_chk++;
            end
            cyc();
        end
        req  = 1'b0;
        stop = 1'b0;
        #1;
        if ({cs_n, oe, busy, rd_vld} !== 4'b1000) begin
            n_err++;
            $display("FAIL %s after-stop: got cs_n,oe,busy,vld=%b want 1000", tag, {cs_n, oe, busy, rd_vld});
        end
        n_chk++;
    endtask

    task automatic test_reset();
        logic [9:0] exp_v;
        do_reset();
        #1;
        exp_v = {2'b00, !INIT_EN, INIT_EN, 4'h0, 1'b0, INIT_EN};
        if ({ctr, cs_n, oe, sio, rd_vld, busy} !== exp_v) begin
            n_err++;
            $display("FAIL reset: got %b want %b", {ctr, cs_n, oe, sio, rd_vld, busy}, exp_v);
        end
        n_chk++;
        skip_init();
    endtask

`ifdef IDLI_SQI_EQIO_INIT_EN
    task automatic test_init();
        logic [7:0] eq;
        logic [3:0] act_v, exp_v;
        eq = 8'h38;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req  = (i == 3);
            addr = 16'($urandom);
            #1;
            act_v = {cs_n, oe, sio[0], busy};
            exp_v = {1'b0, 1'b1, eq[7 - i], 1'b1};
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL init bit%0d: got cs_n,oe,sio0,busy=%b want %b", i, act_v, exp_v);
            end
            n_chk++;
            cyc();
        end
        req = 1'b0;
        #1;
        if ({cs_n, oe, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL init-done: got cs_n,oe,busy=%b want 100", {cs_n, oe, busy});
        end
        n_chk++;
        words[0] = 16'($urandom);
        run_txn(1'b0, 16'($urandom), 1, 1'b0, "init_read");
    endtask
`endif

    task automatic test_read_basic();
        words[0] = 16'hABCD;
        run_txn(1'b0, 16'h1234, 1, 1'b0, "read_1234");
    endtask

    task automatic test_write_basic();
        words[0] = 16'hBEEF;
        run_txn(1'b1, 16'h0040, 1, 1'b0, "write_0040");
    endtask

    task automatic test_stream_read();
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        run_txn(1'b0, 16'($urandom), 3, 1'b0, "stream_read");
    endtask

    task automatic test_req_ignored();
        while (ctr_m != 1) begin
            req = 1'b0;
            cyc();
        end
        req  = 1'b1;
        wr   = 1'b0;
        addr = 16'($urandom);
        cyc();
        cyc();
        req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if ({cs_n, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL req_off_phase cyc%0d: got cs_n,busy=%b want 10", i, {cs_n, busy});
            end
            n_chk++;
            cyc();
        end
    endtask

    task automatic test_reset_abort();
        logic [4:0] exp_v;
        while (ctr_m != 3) begin
            req = 1'b0;
            cyc();
        end
        req  = 1'b1;
        wr   = 1'b0;
        addr = 16'($urandom);
        cyc();
        req = 1'b0;
        cyc();
        cyc();
        cyc();
        #1;
        if (cs_n !== 1'b0) begin
            n_err++;
            $display("FAIL abort-in-addr: got cs_n=%b want 0", cs_n);
        end
        n_chk++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        exp_v = {2'b00, !INIT_EN, INIT_EN, 1'b0};
        if ({ctr, cs_n, oe, rd_vld} !== exp_v) begin
            n_err++;
            $display("FAIL abort-reset: got ctr,cs_n,oe,vld=%b want %b", {ctr, cs_n, oe, rd_vld}, exp_v);
        end
        n_chk++;
        for (int i = 0; i < 12; i++) begin
            cyc();
            #1;
            if (rd_vld !== 1'b0) begin
                n_err++;
                $display("FAIL abort-no-vld cyc%0d: got %b want 0", i, rd_vld);
            end
            n_chk++;
        end
        words[0] = 16'($urandom);
        run_txn(1'b0, 16'($urandom), 1, 1'b0, "read_after_abort");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
            run_txn(1'($urandom), 16'($urandom), 1 + int'($urandom_range(2)), 1'b1, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) words[i] = '0;
        test_reset();
`ifdef IDLI_SQI_EQIO_INIT_EN
        test_init();
`endif
        test_read_basic();
        test_write_basic();
        test_stream_read();
        test_req_ignored();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
